sprint2_rom_loader: RTL and testbench
=====================================

# sprint2_rom_loader

ROM-download sequencer between the MiSTer `hps_io` ioctl stream and the Sprint 2 core.
- Decodes each downloaded byte into one of four ROM regions and forwards it as a registered write.
- Holds the core in reset while no verified image is present, and stretches every reset request.
- Blocks core release when the byte count (and, optionally, the checksum) does not match.
- Owns the core's reset: the top level feeds `~core_reset` to the core's `Reset_n`.

## Interface
Parameters:
- `EXP_BYTES`, 12544 (0x3100): exact byte count of a valid image.
- `HOLD_CYC`, 64: minimum number of `clk_sys` cycles `core_reset` stays high after any reset cause ends.
- `CSUM_EXP`, 16'h0000: expected 16-bit additive checksum (used only with `SPRINT2_LOADER_CSUM_EN`).

Ports:
- `clk_sys`  in  1: system clock (12 MHz); all logic runs on the rising edge.
- `reset`  in  1: asynchronous, active-high; returns the block to BOOT.
- `ioctl_download`  in  1: high for the whole download.
- `ioctl_wr`  in  1: one-cycle byte strobe.
- `ioctl_addr`  in  25: byte address.
- `ioctl_dout`  in  8: byte data.
- `user_reset`  in  1: OSD or button reset request, level.
- `dn_addr`  out  17: registered write address.
- `dn_data`  out  8: registered write data.
- `dn_wr`  out  1: registered write strobe.
- `rgn_we`  out  4: one-hot region write enable, aligned with `dn_wr`. Bit 0 = PROG, 1 = PF, 2 = MOT, 3 = SYNC.
- `core_reset`  out  1: active-high reset to the core.
- `loaded`  out  1: a verified image is present.
- `load_err`  out  1: the last download failed verification.

## Operation
**Regions** (`ioctl_addr[16:0]`):
- PROG 0x0000–0x1FFF
- PF 0x2000–0x27FF
- MOT 0x2800–0x2FFF
- SYNC 0x3000–0x30FF

**States:** BOOT, LOAD, CHECK, HOLD, RUN, FAIL.
- **BOOT** (after `reset`): `core_reset`=1. `ioctl_download` rising → LOAD.
- **LOAD**: `core_reset`=1. Each `ioctl_wr` increments the byte counter.
  - The counter is 17 bits and saturates at all-ones.
  - A write whose `ioctl_addr[24:17]`≠0, or whose address falls outside every region, is counted but produces no `dn_wr` and no `rgn_we` bit.
  - `ioctl_download` falling → CHECK.
- **CHECK** (one cycle):
  - Count == `EXP_BYTES` (and checksum matches when enabled) → HOLD, `loaded`=1, `load_err`=0.
  - Otherwise → FAIL, `loaded`=0, `load_err`=1.
- **HOLD**: `core_reset`=1. The stretch counter loads `HOLD_CYC` on entry and reloads on every cycle `user_reset`=1. It reaches zero with `user_reset`=0 → RUN.
- **RUN**: `core_reset`=0.
  - `user_reset`=1 → HOLD.
  - `ioctl_download` rising → LOAD.
- **FAIL**: `core_reset`=1. `user_reset` is ignored. `ioctl_download` rising → LOAD.
- Entering LOAD from any state:
  - clears the byte counter and checksum;
  - drives `loaded`=0;
  - leaves `load_err` unchanged until the next CHECK.
- In BOOT and FAIL, `user_reset` has no effect.

**Reset values:** state BOOT, `core_reset`=1, `dn_wr`=0, `rgn_we`=0, `dn_addr`=0, `dn_data`=0, `loaded`=0, `load_err`=0, counters 0.

## Timing
- `dn_addr`, `dn_data`, `dn_wr` and `rgn_we` appear exactly 1 cycle after the `ioctl_wr` cycle.
- `dn_wr` and `rgn_we` are single-cycle pulses. Back-to-back `ioctl_wr` gives back-to-back `dn_wr`.
- `ioctl_wr` in the same cycle as the `ioctl_download` fall is counted before CHECK evaluates.
- CHECK is the cycle after the fall. `loaded` and `load_err` update on the CHECK→next transition.
- On a pass with `user_reset`=0, `core_reset` falls exactly `HOLD_CYC`+1 cycles after the CHECK cycle.
- `ioctl_wr` outside LOAD is ignored: no `dn_wr` and no count.
- `reset` asserted mid-download: all outputs go immediately (asynchronously) to their reset values. The block needs a fresh `ioctl_download` rising edge to load again.
- The stretch counter is `$clog2(HOLD_CYC+1)` bits wide.

## Configuration
`SPRINT2_LOADER_CSUM_EN`:
- **Defined**: a 16-bit wrapping sum of all counted bytes (including dropped ones) is kept in LOAD. CHECK passes only if the count matches and sum == `CSUM_EXP`.
- **Undefined**: no checksum logic; CHECK tests the count only, and `CSUM_EXP` is unused.

## Structure
- Shared package `sprint2_pkg` holds:
  - the state enum `loader_state_t`;
  - region index constants `RGN_PROG/PF/MOT/SYNC`;
  - region base and limit localparams, so the core's ROM instantiation uses the same map.
- One sub-module, `rst_stretch`: load/reload/countdown counter with a `done` output, parameterized by `HOLD_CYC`.

## Test plan
1. **Good image**: 0x3100 sequential bytes, then `ioctl_download` falls → 0x3100 `dn_wr` pulses with correct `rgn_we`; `loaded`=1, `load_err`=0; `core_reset` falls 65 cycles after CHECK.
2. **Short image**: 0x30FF bytes → `load_err`=1, `core_reset` stays 1; then a good reload → RUN.
3. **Region decode**: bytes at addresses 0x1FFF, 0x2000, 0x2800, 0x3000 and 0x3100 → `rgn_we` = 0001, 0010, 0100, 1000, then no strobe; count = 5.
4. **User reset**: in RUN, pulse `user_reset` for 10 cycles → `core_reset` high for 10+64 cycles; `user_reset` in FAIL → no change.
5. **Async reset**: assert `reset` at byte 100 → immediate BOOT, outputs at reset values; writes after release ignored until a new download edge.
6. **Checksum** (with `SPRINT2_LOADER_CSUM_EN`, `CSUM_EXP`=sum of image): corrupt one byte → `load_err`=1.

Source files
------------

// File: rtl/sprint2_pkg.sv
// Shared definitions for the Sprint 2 ROM loader and the core's ROM instantiation:
// loader state encoding, region indices and the ROM address map.
package sprint2_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAIL  = 3'd5
    } loader_state_t;

    localparam int RGN_PROG = 0;
    localparam int RGN_PF   = 1;
    localparam int RGN_MOT  = 2;
    localparam int RGN_SYNC = 3;

    // Inclusive [base, last] per region, indexed by RGN_*.
    localparam logic [16:0] RGN_BASE [4] = '{17'h00000, 17'h02000, 17'h02800, 17'h03000};
    localparam logic [16:0] RGN_LAST [4] = '{17'h01FFF, 17'h027FF, 17'h02FFF, 17'h030FF};

    // One-hot region select for a 25-bit ioctl byte address; zero when unmapped.
    function automatic logic [3:0] rgn_decode(input logic [24:0] addr);
        logic [3:0]  we;
        logic [16:0] a;
        we = '0;
        a  = addr[16:0];
        if (addr[24:17] == 8'd0) begin
            for (int r = 0; r < 4; r++) begin
                if (a >= RGN_BASE[r] && a <= RGN_LAST[r]) we[r] = 1'b1;
            end
        end
        return we;
    endfunction

endpackage

// File: rtl/sprint2_rom_loader_if.sv
// ioctl download stream from hps_io plus the registered ROM write port toward the core.
interface sprint2_rom_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [3:0]  rgn_we;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, rgn_we
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, rgn_we
    );
endinterface

// File: rtl/rst_stretch.sv
// Reset stretch down-counter: loads HOLD_CYC, reloads while load is high, counts to zero.
// done flags that the counter is zero on the next cycle.
module rst_stretch #(
    parameter int HOLD_CYC = 64
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    output logic done
);
    localparam int CW = $clog2(HOLD_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)               cnt_d = CW'(HOLD_CYC);
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done = (cnt_d == '0);
endmodule

// File: rtl/sprint2_rom_loader.sv
// ROM-download sequencer: decodes ioctl bytes into Sprint 2 ROM regions and owns core reset.
// Optional checksum verification with `define SPRINT2_LOADER_CSUM_EN.
//
// state | meaning
// BOOT  | after reset, no image; core held in reset
// LOAD  | download active; bytes counted and forwarded
// CHECK | one cycle: verify byte count (and checksum)
// HOLD  | image good; stretching core reset
// RUN   | core released
// FAIL  | image rejected; core held in reset
module sprint2_rom_loader
    import sprint2_pkg::*;
#(
    parameter int EXP_BYTES = 12544,
    parameter int HOLD_CYC  = 64
`ifdef SPRINT2_LOADER_CSUM_EN
    , parameter logic [15:0] CSUM_EXP = 16'h0000
`endif
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    sprint2_rom_loader_if.slave   io,
    input  logic                  user_reset,
    output logic                  core_reset,
    output logic                  loaded,
    output logic                  load_err
);
    localparam logic [2:0] S_BOOT  = ST_BOOT;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_CHECK = ST_CHECK;
    localparam logic [2:0] S_HOLD  = ST_HOLD;
    localparam logic [2:0] S_RUN   = ST_RUN;
    localparam logic [2:0] S_FAIL  = ST_FAIL;

    logic [2:0]  state_q, state_d;
    logic        dl_q, dl_d;
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        dn_wr_q, dn_wr_d;
    logic [3:0]  rgn_we_q, rgn_we_d;
    logic        loaded_q, loaded_d;
    logic        load_err_q, load_err_d;

    logic        dl_rise;
    logic [3:0]  wr_hit;
    logic        pass;
    logic        stretch_load;
    logic        stretch_done;

    assign dl_rise = io.ioctl_download & ~dl_q;
    assign wr_hit  = rgn_decode(io.ioctl_addr);

`ifdef SPRINT2_LOADER_CSUM_EN
    logic [15:0] sum_q, sum_d;
    assign pass = (cnt_q == 17'(EXP_BYTES)) && (sum_q == CSUM_EXP);
`else
    assign pass = (cnt_q == 17'(EXP_BYTES));
`endif

    assign stretch_load = ((state_q == S_CHECK) && pass) ||
                          (((state_q == S_HOLD) || (state_q == S_RUN)) && user_reset);

    rst_stretch #(.HOLD_CYC(HOLD_CYC)) u_rst_stretch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (stretch_load),
        .done    (stretch_done)
    );

    always_comb begin
        state_d    = state_q;
        dl_d       = io.ioctl_download;
        cnt_d      = cnt_q;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        dn_wr_d    = 1'b0;
        rgn_we_d   = 4'b0000;
        loaded_d   = loaded_q;
        load_err_d = load_err_q;
`ifdef SPRINT2_LOADER_CSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            S_BOOT, S_FAIL: begin
                if (dl_rise) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (io.ioctl_wr) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef SPRINT2_LOADER_CSUM_EN
                    sum_d = sum_q + {8'h00, io.ioctl_dout};
`endif
                    if (wr_hit != 4'b0000) begin
                        dn_wr_d   = 1'b1;
                        rgn_we_d  = wr_hit;
                        dn_addr_d = io.ioctl_addr[16:0];
                        dn_data_d = io.ioctl_dout;
                    end
                end
                if (!io.ioctl_download) state_d = S_CHECK;
            end
            S_CHECK: begin
                loaded_d   = pass;
                load_err_d = ~pass;
                state_d    = pass ? S_HOLD : S_FAIL;
            end
            S_HOLD: begin
                if (stretch_done && !user_reset) state_d = S_RUN;
            end
            S_RUN: begin
                if (user_reset)   state_d = S_HOLD;
                else if (dl_rise) state_d = S_LOAD;
            end
            default: state_d = S_BOOT;
        endcase

        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            cnt_d    = '0;
            loaded_d = 1'b0;
`ifdef SPRINT2_LOADER_CSUM_EN
            sum_d    = '0;
`endif
        end
    end

    // dl_q resets high so a download still active across reset is not seen as a new edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_BOOT;
            dl_q       <= 1'b1;
            cnt_q      <= '0;
            dn_addr_q  <= '0;
            dn_data_q  <= '0;
            dn_wr_q    <= 1'b0;
            rgn_we_q   <= 4'b0000;
            loaded_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= dl_d;
            cnt_q      <= cnt_d;
            dn_addr_q  <= dn_addr_d;
            dn_data_q  <= dn_data_d;
            dn_wr_q    <= dn_wr_d;
            rgn_we_q   <= rgn_we_d;
            loaded_q   <= loaded_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef SPRINT2_LOADER_CSUM_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end
`endif

    // user_reset gates the core directly so the request itself is not delayed a cycle.
    assign core_reset = (state_q != S_RUN) | user_reset;
    assign loaded     = loaded_q;
    assign load_err   = load_err_q;
    assign io.dn_addr = dn_addr_q;
    assign io.dn_data = dn_data_q;
    assign io.dn_wr   = dn_wr_q;
    assign io.rgn_we  = rgn_we_q;
endmodule

// File: tb/tb_sprint2_rom_loader.sv
// Directed bench for sprint2_rom_loader: image load, region decode, user/async reset, checksum.
module tb_sprint2_rom_loader;
    logic clk_sys = 1'b0;
    logic reset;
    logic user_reset;
    logic core_reset, loaded, load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int mon_n;
    int mon_err;
    int mon_rgn [4];

    sprint2_rom_loader_if bus();

    always #5 clk_sys = ~clk_sys;

    sprint2_rom_loader #(
        .EXP_BYTES (12544),
        .HOLD_CYC  (64)
`ifdef SPRINT2_LOADER_CSUM_EN
        , .CSUM_EXP (16'h6780)
`endif
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .io         (bus),
        .user_reset (user_reset),
        .core_reset (core_reset),
        .loaded     (loaded),
        .load_err   (load_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_rgn(input logic [16:0] a);
        if (a < 17'h02000) return 4'b0001;
        if (a < 17'h02800) return 4'b0010;
        if (a < 17'h03000) return 4'b0100;
        if (a < 17'h03100) return 4'b1000;
        return 4'b0000;
    endfunction

    always @(negedge clk_sys) begin
        if (bus.dn_wr === 1'b1) begin
            mon_n++;
            for (int b = 0; b < 4; b++) if (bus.rgn_we[b]) mon_rgn[b]++;
            if (bus.rgn_we !== exp_rgn(bus.dn_addr) || bus.dn_data !== bus.dn_addr[7:0]) mon_err++;
        end
    end

    task automatic mon_clear();
        mon_n = 0;
        mon_err = 0;
        for (int b = 0; b < 4; b++) mon_rgn[b] = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, input logic last);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (last) bus.ioctl_download = 1'b0;
        tick(1);
    endtask

    // Sequential image, data = low address byte; last byte coincides with the download fall.
    // Returns at the negedge of the CHECK cycle.
    task automatic image(input int n, input int bad_idx, input bit drop_last);
        logic [24:0] a;
        logic [7:0]  d;
        bus.ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < n; i++) begin
            a = 25'(i);
            if (drop_last && i == n - 1) a = a | 25'h1000000;
            d = 8'(i);
            if (i == bad_idx) d = d ^ 8'h01;
            send(a, d, i == n - 1);
        end
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_low(input int limit, output int cyc);
        cyc = 0;
        while (core_reset && cyc < limit) begin
            cyc++;
            tick(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] ra [5];
        logic [3:0]  re [5];
        int          hi;
        int          c;

        ra = '{25'h1FFF, 25'h2000, 25'h2800, 25'h3000, 25'h3100};
        re = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

        reset = 1'b1;
        user_reset = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = '0;
        mon_clear();
        tick(3);
        check_val("rst_core_reset", core_reset, 1);
        check_val("rst_dn_wr", bus.dn_wr, 0);
        check_val("rst_rgn_we", bus.rgn_we, 0);
        check_val("rst_dn_addr", bus.dn_addr, 0);
        check_val("rst_dn_data", bus.dn_data, 0);
        check_val("rst_loaded", loaded, 0);
        check_val("rst_load_err", load_err, 0);
        reset = 1'b0;
        tick(1);

        send(25'h10, 8'h10, 1'b0);
        bus.ioctl_wr = 1'b0;
        check_val("boot_wr_ignored", bus.dn_wr, 0);
        tick(1);

        // Good image
        mon_clear();
        image(12544, -1, 1'b0);
        check_val("fall_wr_dn_wr", bus.dn_wr, 1);
        check_val("fall_wr_addr", bus.dn_addr, 17'h030FF);
        check_val("check_loaded_old", loaded, 0);
        tick(1);
        check_val("good_loaded", loaded, 1);
        check_val("good_load_err", load_err, 0);
        tick(63);
        check_val("good_hold_64", core_reset, 1);
        tick(1);
        check_val("good_run_65", core_reset, 0);
        check_val("good_dn_count", mon_n, 32'h3100);
        check_val("good_prog_cnt", mon_rgn[0], 32'h2000);
        check_val("good_pf_cnt", mon_rgn[1], 32'h0800);
        check_val("good_mot_cnt", mon_rgn[2], 32'h0800);
        check_val("good_sync_cnt", mon_rgn[3], 32'h0100);
        check_val("good_dn_content", mon_err, 0);

        // User reset in RUN: 10 request cycles + 64 stretch cycles
        hi = 0;
        user_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (core_reset) hi++;
            tick(1);
        end
        user_reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!core_reset) break;
            hi++;
            tick(1);
        end
        check_val("ureset_len", hi, 74);
        check_val("ureset_loaded", loaded, 1);
        tick(1);

        // Region decode, started from RUN
        bus.ioctl_download = 1'b1;
        tick(1);
        check_val("load_clr_loaded", loaded, 0);
        check_val("load_keep_err", load_err, 0);
        check_val("load_core_reset", core_reset, 1);
        for (int k = 0; k < 5; k++) begin
            send(ra[k], ra[k][7:0], k == 4);
            check_val($sformatf("rgn_dn_wr_%0d", k), bus.dn_wr, (k < 4) ? 1 : 0);
            check_val($sformatf("rgn_we_%0d", k), bus.rgn_we, re[k]);
            if (k < 4) check_val($sformatf("rgn_addr_%0d", k), bus.dn_addr, ra[k][16:0]);
        end
        bus.ioctl_wr = 1'b0;
        tick(1);
        check_val("rgn_pulse_end", bus.dn_wr, 0);
        check_val("rgn_load_err", load_err, 1);
        check_val("rgn_loaded", loaded, 0);

        // user_reset in FAIL has no effect
        user_reset = 1'b1;
        tick(5);
        user_reset = 1'b0;
        tick(70);
        check_val("fail_core_reset", core_reset, 1);
        check_val("fail_load_err", load_err, 1);

        // Short image
        image(32'h30FF, -1, 1'b0);
        tick(1);
        check_val("short_load_err", load_err, 1);
        check_val("short_loaded", loaded, 0);
        tick(80);
        check_val("short_core_reset", core_reset, 1);

        // Async reset at byte 100
        bus.ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 100; i++) send(25'(i), 8'(i), 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("arst_core_reset", core_reset, 1);
        check_val("arst_dn_wr", bus.dn_wr, 0);
        check_val("arst_rgn_we", bus.rgn_we, 0);
        check_val("arst_dn_addr", bus.dn_addr, 0);
        check_val("arst_dn_data", bus.dn_data, 0);
        check_val("arst_loaded", loaded, 0);
        check_val("arst_load_err", load_err, 0);
        tick(1);
        reset = 1'b0;
        mon_clear();
        for (int i = 100; i < 120; i++) send(25'(i), 8'(i), 1'b0);
        bus.ioctl_wr = 1'b0;
        tick(2);
        check_val("arst_wr_ignored", mon_n, 0);
        check_val("arst_core_held", core_reset, 1);
        bus.ioctl_download = 1'b0;
        tick(2);

        // Fresh download; last byte maps nowhere but still counts toward the total
        image(12544, -1, 1'b1);
        check_val("reload_dropped_no_wr", bus.dn_wr, 0);
        tick(1);
        check_val("reload_loaded", loaded, 1);
        check_val("reload_load_err", load_err, 0);
        wait_low(100, c);
        check_val("reload_hold_cycles", c, 64);

`ifdef SPRINT2_LOADER_CSUM_EN
        image(12544, 5, 1'b0);
        tick(1);
        check_val("csum_bad_load_err", load_err, 1);
        check_val("csum_bad_loaded", loaded, 0);
        tick(70);
        check_val("csum_bad_core_reset", core_reset, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
